// File: rtl/byte_striping_pkg.sv
// rtl/byte_striping_pkg.sv - shared symbol constants, FSM states and helpers for the byte striping link
package byte_striping_pkg;

  localparam logic [7:0] STP = 8'hFB;
  localparam logic [7:0] SDP = 8'h5C;
  localparam logic [7:0] END = 8'hFD;
  localparam logic [7:0] EDB = 8'hFE;
  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] SKP = 8'h1C;
  localparam logic [7:0] IDL = 8'h7C;

  typedef enum logic [1:0] {IDLE, PKT, HOLD} state_t;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_WRITE,
    OP_WRITE_PAD,
    OP_PAD_FLUSH,
    OP_PAD_RESTART,
    OP_BCAST,
    OP_CLEAR
  } acc_op_t;

  function automatic logic is_frame_start(input logic [7:0] d, input logic k);
    return k && (d == STP || d == SDP);
  endfunction

  function automatic logic is_frame_end(input logic [7:0] d, input logic k);
    return k && (d == END || d == EDB);
  endfunction

  function automatic logic is_bcast(input logic [7:0] d, input logic k);
    return k && (d == COM || d == SKP);
  endfunction

endpackage

// File: rtl/byte_striper_n_if.sv
// rtl/byte_striper_n_if.sv - symbol input and striped word output bundle of the striper
interface byte_striper_n_if #(
  parameter int LANES = 4,
  parameter int W     = 8
);
  logic [W-1:0]       d;
  logic               dk;
  logic               in_valid;
  logic               in_ready;
  logic [LANES*W-1:0] lane;
  logic [LANES-1:0]   lane_k;
  logic               out_valid;
  logic               err;

  modport master (output d, dk, in_valid,
                  input  in_ready, lane, lane_k, out_valid, err);
  modport slave  (input  d, dk, in_valid,
                  output in_ready, lane, lane_k, out_valid, err);
endinterface

// File: rtl/byte_striper_n_stripe_accum.sv
// rtl/byte_striper_n_stripe_accum.sv - LANES-slot symbol accumulator with write, pad/flush and broadcast
module stripe_accum
  import byte_striping_pkg::*;
#(
  parameter int LANES = 4,
  parameter int W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  acc_op_t            op,
  input  logic [W-1:0]       sym,
  input  logic               sym_k,
  output logic               ptr_zero,
  output logic [LANES*W-1:0] word,
  output logic [LANES-1:0]   word_k,
  output logic               done
);
  localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [PW-1:0] LAST = PW'(LANES - 1);

  logic [W-1:0]       slot_d [LANES];
  logic [LANES-1:0]   slot_k;
  logic [PW-1:0]      ptr;
  logic [W-1:0]       nd [LANES];
  logic [LANES-1:0]   nk;
  logic [LANES*W-1:0] nword;
  logic               emit;

  assign ptr_zero = (ptr == '0);

  // Outgoing word is the stored slots overlaid with this cycle's operation.
  always_comb begin
    nk    = slot_k;
    emit  = 1'b0;
    nword = '0;
    for (int i = 0; i < LANES; i++) nd[i] = slot_d[i];
    case (op)
      OP_WRITE: begin
        nd[ptr] = sym;
        nk[ptr] = sym_k;
        emit    = (ptr == LAST);
      end
      OP_WRITE_PAD, OP_PAD_FLUSH, OP_PAD_RESTART: begin
        for (int i = 0; i < LANES; i++) begin
          if (PW'(i) == ptr && op == OP_WRITE_PAD) begin
            nd[i] = sym;
            nk[i] = sym_k;
          end else if (PW'(i) >= ptr) begin
            nd[i] = W'(IDL);
            nk[i] = 1'b1;
          end
        end
        emit = 1'b1;
      end
      OP_BCAST: begin
        for (int i = 0; i < LANES; i++) nd[i] = sym;
        nk   = {LANES{sym_k}};
        emit = 1'b1;
      end
      default: ;
    endcase
    for (int i = 0; i < LANES; i++) nword[i*W +: W] = nd[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr    <= '0;
      slot_k <= '0;
      for (int i = 0; i < LANES; i++) slot_d[i] <= '0;
      word   <= '0;
      word_k <= '0;
      done   <= 1'b0;
    end else begin
      done <= emit;
      if (emit) begin
        word   <= nword;
        word_k <= nk;
      end
      case (op)
        OP_WRITE: begin
          slot_d[ptr] <= sym;
          slot_k[ptr] <= sym_k;
          ptr         <= (ptr == LAST) ? '0 : ptr + 1'b1;
        end
        OP_PAD_RESTART: begin
          slot_d[0] <= sym;
          slot_k[0] <= sym_k;
          ptr       <= PW'(LANES > 1);
        end
        OP_WRITE_PAD, OP_PAD_FLUSH, OP_BCAST, OP_CLEAR: ptr <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/byte_striper_n.sv
// rtl/byte_striper_n.sv - transmit byte striper: framing FSM around the lane accumulator
module byte_striper_n
  import byte_striping_pkg::*;
#(
  parameter int LANES = 4,
  parameter int W     = 8
) (
  input logic             clk,
  input logic             rst,
  byte_striper_n_if.slave bus
);
  state_t       state, state_n;
  logic [W-1:0] hold_d, hold_d_n;
  acc_op_t      op;
  logic [W-1:0] sym;
  logic         sym_k;
  logic         drop;
  logic         ptr_zero;
  logic         accept;
  logic         in_ready_q;
  logic         err_q;
  logic [7:0]   d8;

  assign d8     = 8'(bus.d);
  assign accept = bus.in_valid & in_ready_q;

  always_comb begin
    state_n  = state;
    hold_d_n = hold_d;
    op       = OP_NONE;
    sym      = bus.d;
    sym_k    = bus.dk;
    drop     = 1'b0;
    case (state)
      IDLE: if (accept) begin
        if (is_frame_start(d8, bus.dk)) begin
          op      = OP_WRITE;
          state_n = PKT;
        end else if (is_bcast(d8, bus.dk)) begin
          op = OP_BCAST;
        end else if (!(bus.dk && d8 == IDL)) begin
          drop = 1'b1;
        end
      end
      PKT: if (accept) begin
        if (is_frame_end(d8, bus.dk)) begin
          op      = OP_WRITE_PAD;
          state_n = IDLE;
        end else if (is_frame_start(d8, bus.dk)) begin
          op = ptr_zero ? OP_WRITE : OP_PAD_RESTART;
        end else if (is_bcast(d8, bus.dk)) begin
          if (ptr_zero) begin
            op = OP_BCAST;
          end else begin
            op       = OP_PAD_FLUSH;
            hold_d_n = bus.d;
            state_n  = HOLD;
          end
        end else begin
          op = OP_WRITE;
        end
      end
      HOLD: begin
        op      = OP_BCAST;
        sym     = hold_d;
        sym_k   = 1'b1;
        state_n = PKT;
      end
      default: state_n = IDLE;
    endcase
  end

  // Ready is registered, so it drops exactly for the cycle spent in HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hold_d     <= '0;
      in_ready_q <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state      <= state_n;
      hold_d     <= hold_d_n;
      in_ready_q <= (state_n != HOLD);
      err_q      <= drop;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.err      = err_q;

  stripe_accum #(.LANES(LANES), .W(W)) u_accum (
    .clk      (clk),
    .rst      (rst),
    .op       (op),
    .sym      (sym),
    .sym_k    (sym_k),
    .ptr_zero (ptr_zero),
    .word     (bus.lane),
    .word_k   (bus.lane_k),
    .done     (bus.out_valid)
  );

endmodule

// File: tb/tb_byte_striper_n.sv
// tb/tb_byte_striper_n.sv - directed self-checking bench for byte_striper_n with LANES=4, W=8
module tb_byte_striper_n;
  import byte_striping_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  byte_striper_n_if #(.LANES(4), .W(8)) bus ();

  byte_striper_n #(.LANES(4), .W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [35:0] words[$];
  int          errs;
  int          rdy_low;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid) words.push_back({bus.lane_k, bus.lane});
      if (bus.err) errs++;
      if (!bus.in_ready) rdy_low++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic k);
    int n = 0;
    while (!bus.in_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (n == 8) check("ready_timeout", 64'd0, 64'd1);
    bus.d        = d;
    bus.dk       = k;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic start_case();
    words.delete();
    errs    = 0;
    rdy_low = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_word(input string tag, input logic [31:0] lane, input logic [3:0] k);
    logic [35:0] w;
    if (words.size() == 0) begin
      check({tag, "_missing"}, 64'd0, 64'd1);
    end else begin
      w = words.pop_front();
      check(tag, 64'(w[31:0]), 64'(lane));
      check({tag, "_k"}, 64'(w[35:32]), 64'(k));
    end
  endtask

  initial begin
    bus.d        = '0;
    bus.dk       = 1'b0;
    bus.in_valid = 1'b0;
    errs         = 0;
    rdy_low      = 0;
    repeat (3) @(negedge clk);
    check("rst_lane", 64'(bus.lane), 64'd0);
    check("rst_lane_k", 64'(bus.lane_k), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    start_case();
    send(STP, 1'b1); send(8'h11, 1'b0); send(8'h22, 1'b0); send(END, 1'b1);
    check("short_latency", 64'(bus.out_valid), 64'd1);
    idle(3);
    check("short_count", 64'(words.size()), 64'd1);
    expect_word("short_w0", 32'hFD2211FB, 4'b1001);

    start_case();
    send(STP, 1'b1); send(8'h11, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_lane", 64'(bus.lane), 64'd0);
    check("arst_lane_k", 64'(bus.lane_k), 64'd0);
    check("arst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(STP, 1'b1); send(8'h22, 1'b0); send(8'h33, 1'b0); send(END, 1'b1);
    idle(3);
    check("arst_count", 64'(words.size()), 64'd1);
    expect_word("arst_w0", 32'hFD3322FB, 4'b1001);

    start_case();
    send(STP, 1'b1); send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
    send(8'h44, 1'b0); send(END, 1'b1);
    idle(3);
    check("pad_count", 64'(words.size()), 64'd2);
    expect_word("pad_w0", 32'h332211FB, 4'b0001);
    expect_word("pad_w1", 32'h7C7CFD44, 4'b1110);

    start_case();
    send(STP, 1'b1); send(8'h11, 1'b0); send(COM, 1'b1); send(8'h22, 1'b0); send(END, 1'b1);
    idle(3);
    check("bc_ready_low", 64'(rdy_low), 64'd1);
    check("bc_count", 64'(words.size()), 64'd3);
    expect_word("bc_w0", 32'h7C7C11FB, 4'b1101);
    expect_word("bc_w1", 32'hBCBCBCBC, 4'b1111);
    expect_word("bc_w2", 32'h7C7CFD22, 4'b1110);

    start_case();
    send(STP, 1'b1); send(8'h11, 1'b0); send(SDP, 1'b1); send(8'h22, 1'b0); send(END, 1'b1);
    idle(3);
    check("impl_count", 64'(words.size()), 64'd2);
    expect_word("impl_w0", 32'h7C7C11FB, 4'b1101);
    expect_word("impl_w1", 32'h7CFD225C, 4'b1101);

    start_case();
    send(8'h55, 1'b0); send(END, 1'b1);
    idle(2);
    check("ill_err_count", 64'(errs), 64'd2);
    check("ill_no_word", 64'(words.size()), 64'd0);
    send(COM, 1'b1);
    idle(2);
    check("ill_com_count", 64'(words.size()), 64'd1);
    expect_word("ill_com_w", 32'hBCBCBCBC, 4'b1111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/byte_striper_n.md
Name: byte_striper_n

Overview:
- Parametrised transmit-side byte striper for the byte_striping link.
- Takes a serial symbol stream (D plus K-flag DK, one symbol per accepted cycle) and distributes it round-robin across LANES lanes.
- Aligns framing symbols (STP/SDP) to lane 0 and pads partial words after END/EDB with IDL.
- Broadcasts ordered-set symbols (COM, SKP) to all lanes at once.
- Sits between the link-layer framer and the per-lane encoders.

Parameters:
- LANES, 4, number of output lanes; legal values 1, 2, 4, 8, 16.
- W, 8, symbol width in bits.

Ports:
- CLK  input  1  clock; all logic is on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- D  input  W  input symbol.
- DK  input  1  1 = D is a K (control) symbol.
- IN_VALID  input  1  D/DK valid this cycle.
- IN_READY  output  1  striper can accept a symbol; a symbol is accepted when IN_VALID & IN_READY.
- LANE  output  LANES*W  striped word; lane i occupies bits [i*W +: W].
- LANE_K  output  LANES  per-lane K flag.
- OUT_VALID  output  1  LANE/LANE_K hold a new word this cycle (single-cycle pulse per word).
- ERR  output  1  one-cycle pulse when an input symbol is dropped as illegal.

Behaviour:
- Symbol constants (8-bit): STP=FB, SDP=5C, END=FD, EDB=FE, COM=BC, SKP=1C, IDL=7C. They are matched only when DK=1.
- Reset values: LANE=0, LANE_K=0, OUT_VALID=0, ERR=0, IN_READY=1. Internal state: lane pointer PTR=0, state=IDLE, accumulator cleared.
- Reset asserted mid-word discards any partial accumulator contents with no flush.
- All outputs are registered. A word is presented on the cycle after the symbol that completes it is accepted, i.e. 1-cycle latency.
- Accumulator: LANES slots of {K,W}. An accepted packet symbol is written to slot PTR, then PTR increments. When PTR would wrap from LANES-1 to 0, the full word is emitted and PTR returns to 0.
- FSM states:
  - IDLE: outside a packet.
  - PKT: inside a packet.
  - HOLD: a broadcast symbol is waiting while a partial word is flushed.
- IDLE transitions:
  - STP/SDP: written to lane 0, PTR=1, go to PKT.
  - COM/SKP: emit a word with every lane = symbol and LANE_K all ones; stay in IDLE.
  - IDL: accepted and discarded.
  - Data (DK=0), END or EDB: dropped and ERR pulses.
- PKT transitions:
  - Data, or K symbols other than those below: striped normally.
  - END/EDB: written to slot PTR. Remaining slots above it are filled with IDL (K=1) and the word is emitted the next cycle. PTR=0, go to IDLE.
  - STP/SDP while PTR!=0: treated as an implicit end. Slots PTR..LANES-1 are filled with IDL and emitted. The new STP/SDP is written to lane 0, PTR=1, stay in PKT.
  - STP/SDP while PTR==0: written to lane 0; no padding word.
  - COM/SKP while PTR!=0: the partial word is padded with IDL and emitted. The symbol is latched, IN_READY=0 for exactly one cycle, go to HOLD.
  - COM/SKP while PTR==0: broadcast immediately; stay in PKT.
- HOLD: emit the broadcast word, IN_READY returns to 1, PTR=0, return to PKT.
- At most one word is emitted per cycle. Consecutive emitting cycles give back-to-back OUT_VALID pulses.
- When IN_VALID=0, no state change occurs and partial words are held indefinitely.
- LANES=1: every accepted legal symbol emits one word; padding never occurs.
- ERR and OUT_VALID can both be 1 in the same cycle only when the previous symbol completed a word and the current symbol is dropped.

Decomposition:
- Package byte_striping_pkg holds:
  - the symbol constants STP, SDP, END, EDB, COM, SKP, IDL;
  - the state enum {IDLE, PKT, HOLD};
  - a function is_frame_start(d,k), shared with the receive-side unstriper.
- One sub-module, stripe_accum. It holds the LANES-slot accumulator and pointer, with operations write, pad_flush, broadcast and clear. It outputs the word and a done strobe. The FSM stays in byte_striper_n.

Test Plan:
All cases use LANES=4, W=8; lanes are listed lane0..lane3.
- Reset check: assert RESET mid-packet after STP,11 → outputs are 0 immediately (async). After release, IN_READY=1 and the next STP starts on lane 0.
- Short packet: STP,11,22,END → one word {FB,11,22,FD}, LANE_K=1001, OUT_VALID pulses 1 cycle after END.
- Padded packet: STP,11,22,33,44,END → {FB,11,22,33} K=1000, then {44,FD,7C,7C} K=0111.
- Broadcast mid-packet: STP,11,COM,22,END → {FB,11,7C,7C} K=1011; IN_READY low 1 cycle; then {BC,BC,BC,BC} K=1111; then {22,FD,7C,7C} K=0111.
- Implicit end: STP,11,SDP,22,END → {FB,11,7C,7C}, then {5C,22,FD,7C}.
- Illegal in IDLE: data 55 with DK=0, then END → two ERR pulses, no OUT_VALID. A following COM then gives an all-BC word.
